dtcctf_trg_encoder: RTL

//  Serial trigger-frame transmitter for the DTC link: the sending end of the trigger line that

---
 rtl/dtcctf_pkg.sv | 37 +++
 rtl/dtcctf_cmd_fifo.sv | 61 ++++++
 rtl/dtcctf_trg_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dtcctf_pkg.sv
// Shared definitions for the DTC trigger-frame encoder: frame type codes,
// queued command layout and small helpers used by the top and its FIFO.
package dtcctf_pkg;

    localparam int FRAME_LEN = 17;
    localparam int CMD_W     = 14;

    typedef enum logic [1:0] {
        TRG_PHYS = 2'b00,
        TRG_ECR  = 2'b01,
        TRG_TP   = 2'b10
    } trg_type_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } enc_state_e;

    // START, TYPE, DATA, even parity over TYPE+DATA, STOP; MSB leaves first.
    function automatic logic [FRAME_LEN-1:0] build_frame(input cmd_t c);
        return {1'b1, c.kind, c.data, ^{c.kind, c.data}, 1'b0};
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/dtcctf_cmd_fifo.sv
// Synchronous command FIFO for pending trigger frames; flush empties it
// without touching the stored words.
module dtcctf_cmd_fifo
    import dtcctf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dtcctf_trg_encoder.sv
// Serial trigger-frame transmitter: arbitrates physics/ECR/test-pulse requests,
// queues them and shifts 17-bit frames out on trg_ser with a forced idle gap.
module dtcctf_trg_encoder
    import dtcctf_pkg::*;
#(
    parameter int BIT_DIV = 4,
    parameter int QDEPTH  = 4,
    parameter int MIN_GAP = 8
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic [7:0]  cfg,
    input  logic        trg_req,
    input  logic        ecr_req,
    input  logic        tp_req,
    output logic        trg_ser,
    output logic        busy,
    output logic [11:0] evcnt,
    output logic [15:0] sent_cnt,
    output logic [15:0] drop_cnt
);

    localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int IW = $clog2((MIN_GAP > FRAME_LEN) ? MIN_GAP : FRAME_LEN);

    logic enable;
    logic invert;
    logic unused_cfg;

    assign enable     = cfg[0];
    assign invert     = cfg[1];
    assign unused_cfg = ^cfg[7:2];

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    cmd_t       fifo_rdata;
    cmd_t       req_cmd;
    logic [1:0] n_req;
    logic [1:0] n_drop;
    logic       accept;

    // One winner per cycle (ECR > physics > test pulse); the losers are drops.
    always_comb begin
        n_req        = {1'b0, trg_req} + {1'b0, ecr_req} + {1'b0, tp_req};
        req_cmd.kind = TRG_TP;
        req_cmd.data = '0;
        if (ecr_req) begin
            req_cmd.kind = TRG_ECR;
        end else if (trg_req) begin
            req_cmd.kind = TRG_PHYS;
            req_cmd.data = evcnt;
        end
        accept = (n_req != 2'd0) && enable && !fifo_full;
        n_drop = accept ? (n_req - 2'd1) : n_req;
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            evcnt <= '0;
        end else if (accept) begin
            if (ecr_req) begin
                evcnt <= '0;
            end else if (trg_req) begin
                evcnt <= evcnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (n_drop != 2'd0) begin
            drop_cnt <= sat_add16(drop_cnt, n_drop);
        end
    end

    // Disabling flushes whatever is still queued; the frame on the wire completes.
    dtcctf_cmd_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk0),
        .rst   (rst),
        .flush (!enable),
        .push  (accept),
        .wdata (req_cmd),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    enc_state_e           state;
    logic [TW-1:0]        bit_tmr;
    logic [IW-1:0]        bit_idx;
    logic [FRAME_LEN-1:0] shreg;
    logic                 bit_end;

    assign bit_end  = (bit_tmr == TW'(BIT_DIV - 1));
    assign fifo_pop = (state == ST_IDLE) && enable && !fifo_empty;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk0) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            trg_ser  <= invert;
            sent_cnt <= '0;
        end else begin
            trg_ser <= invert;
            bit_tmr <= bit_end ? '0 : bit_tmr + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shreg <= build_frame(fifo_rdata);
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    trg_ser <= shreg[FRAME_LEN-1] ^ invert;
                    bit_tmr <= '0;
                    bit_idx <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!bit_end) begin
                        trg_ser <= shreg[FRAME_LEN-1] ^ invert;
                    end else if (bit_idx == IW'(FRAME_LEN - 1)) begin
                        bit_idx  <= '0;
                        sent_cnt <= sat_add16(sent_cnt, 2'd1);
                        state    <= ST_GAP;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
                        trg_ser <= shreg[FRAME_LEN-2] ^ invert;
                    end
                end
                ST_GAP: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IW'(MIN_GAP - 1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
